// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between a fifo_buffer and fifo_uart_tx.
// Signal names are from the transmitter's point of view.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_fifo_empty;
    logic [DATA_WIDTH-1:0] in_fifo_data;
    logic                  out_fifo_read;

    modport master (
        input  in_fifo_empty,
        input  in_fifo_data,
        output out_fifo_read
    );

    modport slave (
        output in_fifo_empty,
        output in_fifo_data,
        input  out_fifo_read
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO one word per frame onto an LSB-first UART line (start, data, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic           in_clk,
    input  logic           in_rst,
    input  logic           in_clke,
    input  logic           in_en,
    fifo_uart_tx_if.master fifo_rd,
    output logic           out_tx,
    output logic           out_busy,
    output logic           out_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state, w_state_next;
    logic [BAUD_W-1:0]     r_baud, w_baud_next;
    logic [BIT_W-1:0]      r_bit, w_bit_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic                  r_tx, w_tx_next;
    logic                  r_fifo_read, w_fifo_read_next;
    logic                  r_done, w_done_next;
    logic                  w_tick;
    logic                  w_bit_end;
    logic [DATA_WIDTH-1:0] w_shift_dn;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  r_parity, w_parity_next;
`endif

    assign w_tick     = in_clke & in_en;
    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_shift_dn = r_shift >> 1;

    // NOTE: every next-value gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next     = r_state;
        w_baud_next      = r_baud;
        w_bit_next       = r_bit;
        w_shift_next     = r_shift;
        w_tx_next        = r_tx;
        w_fifo_read_next = r_fifo_read;
        w_done_next      = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next    = r_parity;
`endif
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_tx_next        = 1'b1;
                    w_fifo_read_next = 1'b0;
                    if (!fifo_rd.in_fifo_empty) begin
                        w_state_next     = S_POP;
                        w_fifo_read_next = 1'b1;
                    end
                end
                S_POP: begin
                    w_fifo_read_next = 1'b0;
                    w_state_next     = S_LOAD;
                end
                S_LOAD: begin
                    w_shift_next  = fifo_rd.in_fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    w_parity_next = ^fifo_rd.in_fifo_data;
`endif
                    w_tx_next     = 1'b0;
                    w_baud_next   = '0;
                    w_bit_next    = '0;
                    w_state_next  = S_START;
                end
                S_START: begin
                    w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        w_tx_next    = r_shift[0];
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        w_shift_next = w_shift_dn;
                        w_bit_next   = r_bit + 1'b1;
                        w_tx_next    = w_shift_dn[0];
                        if (r_bit == DATA_LAST) begin
                            w_bit_next   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            w_tx_next    = r_parity;
                            w_state_next = S_PARITY;
`else
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
`endif
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                    if (w_bit_end) begin
                        w_bit_next = r_bit + 1'b1;
                        if (r_bit == STOP_LAST) begin
                            // Frame end: chain straight into the next pop when data is waiting.
                            w_bit_next   = '0;
                            w_done_next  = 1'b1;
                            w_state_next = fifo_rd.in_fifo_empty ? S_IDLE : S_POP;
                            w_fifo_read_next = ~fifo_rd.in_fifo_empty;
                        end
                    end
                end
                default: begin
                    w_tx_next    = 1'b1;
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_fifo_read <= 1'b0;
            r_done      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_baud      <= w_baud_next;
            r_bit       <= w_bit_next;
            r_shift     <= w_shift_next;
            r_tx        <= w_tx_next;
            r_fifo_read <= w_fifo_read_next;
            r_done      <= w_done_next;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity    <= w_parity_next;
`endif
        end
    end

    assign fifo_rd.out_fifo_read = r_fifo_read;
    assign out_tx   = r_tx;
    assign out_busy = (r_state != S_IDLE);
    assign out_done = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a per-tick expected-line model built from frame rules,
// checked every in_clk cycle; honours FIFO_UART_TX_PARITY_EN when defined.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;

    typedef struct packed {
        logic tx;
        logic rd;
        logic busy;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clke;
    logic en;
    logic tx;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) fifo_if ();

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .in_clk  (clk),
        .in_rst  (rst),
        .in_clke (clke),
        .in_en   (en),
        .fifo_rd (fifo_if),
        .out_tx  (tx),
        .out_busy(busy),
        .out_done(done)
    );

    exp_t          stream[$];
    exp_t          cur;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] batch_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_seen = 0;
    int            rd_seen = 0;

    function automatic exp_t mk(input logic t, input logic r, input logic b, input logic d);
        exp_t e;
        e.tx = t; e.rd = r; e.busy = b; e.done = d;
        return e;
    endfunction

    function automatic void push_bit(input logic v);
        for (int k = 0; k < CPB; k++) stream.push_back(mk(v, 1'b0, 1'b1, 1'b0));
    endfunction

    // Expected line, one record per tick: two high ticks (pop, load), then each frame bit for CPB ticks.
    function automatic void commit();
        for (int i = 0; i < batch_q.size(); i++) begin
            logic [DW-1:0] w;
            w = batch_q[i];
            fifo_q.push_back(w);
            stream.push_back(mk(1'b1, 1'b1, 1'b1, i != 0));
            stream.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
            push_bit(1'b0);
            for (int b = 0; b < DW; b++) push_bit(w[b]);
`ifdef FIFO_UART_TX_PARITY_EN
            push_bit(^w);
`endif
            for (int s = 0; s < SB; s++) push_bit(1'b1);
        end
        stream.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
        batch_q.delete();
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Called at a falling edge: drive the next edge's inputs, model that edge, check at the next falling edge.
    task automatic run_cycle(input logic clke_v, input logic en_v, input logic rst_v);
        rst  = rst_v;
        clke = clke_v;
        en   = en_v;
        if (!rst_v && clke_v && en_v && fifo_if.out_fifo_read === 1'b1 && fifo_q.size() > 0)
            fifo_if.in_fifo_data = fifo_q.pop_front();
        fifo_if.in_fifo_empty = (fifo_q.size() == 0);
        @(posedge clk);
        if (rst_v) begin
            stream.delete();
            cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
        end else if (clke_v && en_v) begin
            cur = (stream.size() > 0) ? stream.pop_front() : mk(1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            cur.done = 1'b0;
        end
        @(negedge clk);
        chk("tx", tx, cur.tx);
        chk("fifo_read", fifo_if.out_fifo_read, cur.rd);
        chk("busy", busy, cur.busy);
        chk("done", done, cur.done);
        if (done === 1'b1) done_seen++;
        if (fifo_if.out_fifo_read === 1'b1) rd_seen++;
    endtask

    // mode 0: always enabled; 1: clke every 2nd cycle; 2: random clke and occasional en drops.
    task automatic drain(input int mode);
        for (int i = 0; i < 4000 && stream.size() != 0; i++) begin
            case (mode)
                0:       run_cycle(1'b1, 1'b1, 1'b0);
                1:       run_cycle(1'(i % 2), 1'b1, 1'b0);
                default: run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 1'b0);
            endcase
        end
        chk_int("drain_timeout", stream.size(), 0);
        repeat (3) run_cycle(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        clke = 1'b1;
        en   = 1'b1;
        fifo_if.in_fifo_empty = 1'b1;
        fifo_if.in_fifo_data  = '0;
        cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held 3 cycles while the FIFO reports data.
        fifo_q.push_back(8'h5A);
        repeat (3) run_cycle(1'b1, 1'b1, 1'b1);
        fifo_q.delete();
        repeat (4) run_cycle(1'b1, 1'b1, 1'b0);

        // Single byte 0xA5.
        done_seen = 0; rd_seen = 0;
        batch_q.push_back(8'hA5);
        commit();
        drain(0);
        chk_int("a5_read_cycles", rd_seen, 1);
        chk_int("a5_done_pulses", done_seen, 1);

        // Back-to-back 0x00 then 0xFF.
        done_seen = 0;
        batch_q.push_back(8'h00);
        batch_q.push_back(8'hFF);
        commit();
        drain(0);
        chk_int("b2b_done_pulses", done_seen, 2);
        chk_int("b2b_fifo_left", fifo_q.size(), 0);

        // Empty FIFO for 200 cycles.
        rd_seen = 0;
        repeat (200) run_cycle(1'b1, 1'b1, 1'b0);
        chk_int("empty_read_cycles", rd_seen, 0);

        // clke every 2nd cycle, byte 0x3C, with in_en dropped 10 cycles mid-data.
        batch_q.push_back(8'h3C);
        commit();
        for (int i = 0; i < 32; i++) run_cycle(1'(i % 2), 1'b1, 1'b0);
        repeat (10) run_cycle(1'b1, 1'b0, 1'b0);
        drain(1);

        // Reset during data bit 3 aborts the frame.
        batch_q.push_back(8'($urandom));
        commit();
        repeat (20) run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b1);
        repeat (6) run_cycle(1'b1, 1'b1, 1'b0);
        chk_int("abort_fifo_left", fifo_q.size(), 0);

        // 0x07 (odd population) followed by a random word.
        batch_q.push_back(8'h07);
        batch_q.push_back(8'($urandom));
        commit();
        drain(0);

        // Random batches under random enable gating.
        for (int n = 0; n < 6; n++) begin
            int cnt;
            cnt = $urandom_range(1, 3);
            done_seen = 0;
            for (int k = 0; k < cnt; k++) batch_q.push_back(8'($urandom));
            commit();
            drain(2);
            chk_int("rand_done_pulses", done_seen, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
